// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller: one A_WIDTH-bit adder (carry kept)
// reused over up to B_WIDTH iterations. Optional build macro: MULT_EARLY_TERM_EN.
module mult_seq_ctrl #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [A_WIDTH-1:0]         a_in,
  input  logic [B_WIDTH-1:0]         b_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       zero,
  output logic                       busy
);

  localparam int CW = $clog2(B_WIDTH + 1);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam logic [CW-1:0] B_LAST = CW'(B_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [A_WIDTH-1:0] a_reg;
  logic [A_WIDTH-1:0] acc;
  logic [B_WIDTH-1:0] b_reg;
  logic [CW-1:0]      cnt;

  logic [A_WIDTH:0]   sum;
  logic [PW:0]        wide;
  logic [PW-1:0]      next_pair;
  logic               last_iter;

`ifdef MULT_EARLY_TERM_EN
  localparam logic [CW-1:0] B_FULL = CW'(B_WIDTH);
  logic [B_WIDTH-1:0] win_mask;
  logic               rest_zero;
  logic [CW-1:0]      shamt;
`endif

  always_comb begin
    sum  = {1'b0, acc} + (b_reg[0] ? {1'b0, a_reg} : '0);
    wide = {sum, b_reg};
`ifdef MULT_EARLY_TERM_EN
    // Low (B_WIDTH-cnt) bits of b_reg are still multiplier bits; once nothing
    // above the current bit is set, the remaining iterations are pure shifts.
    win_mask  = {B_WIDTH{1'b1}} >> cnt;
    rest_zero = ((b_reg & win_mask) >> 1) == '0;
    shamt     = B_FULL - cnt;
    last_iter = rest_zero || (cnt == B_LAST);
    next_pair = rest_zero ? PW'(wide >> shamt) : PW'(wide >> 1);
`else
    last_iter = (cnt == B_LAST);
    next_pair = PW'(wide >> 1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      acc   <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= a_in;
            acc   <= '0;
            b_reg <= b_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          {acc, b_reg} <= next_pair;
          cnt          <= cnt + CW'(1);
          if (last_iter) state <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state == RUN);
  assign res_valid   = (state == DONE);
  assign product     = res_valid ? {acc, b_reg} : '0;
  assign zero        = res_valid && ({acc, b_reg} == '0);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed + random bench for mult_seq_ctrl with a product scoreboard queue.
module tb_mult_seq_ctrl;

  localparam int A = 8;
  localparam int B = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [A-1:0]   a_in;
  logic [B-1:0]   b_in;
  logic           res_valid;
  logic           res_ready;
  logic [A+B-1:0] product;
  logic           zero;
  logic           busy;

  int             nchk = 0;
  int             nerr = 0;
  bit             tie_ready = 1'b0;
  logic [A+B-1:0] sb[$];

  mult_seq_ctrl #(.A_WIDTH(A), .B_WIDTH(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .product(product), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_runs(input logic [B-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < B; i++) if (b[i]) n = i + 1;
    return n;
`else
    return B;
`endif
  endfunction

  // Called just after a negedge with the controller in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input logic [A-1:0] a, input logic [B-1:0] b,
                       input int hold, input bit pulse);
    logic [A+B-1:0] exp_p;
    int  runs;
    int  edges;
    bit  seen;
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    sb.push_back((A+B)'(a) * (A+B)'(b));
    @(negedge clk);
    start_valid = pulse;
    a_in = ~a;
    b_in = ~b;
    runs  = 0;
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 4 * B + 8 && !seen; i++) begin
      if (res_valid) seen = 1'b1;
      else begin
        if (busy) runs++;
        @(negedge clk);
        edges++;
      end
    end
    chk("res_valid_seen", seen, 1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    chk("run_cycles", runs, exp_runs(b));
    chk("latency_edges", edges, exp_runs(b) + 1);
    chk("busy_in_done", busy, 0);
    chk("start_ready_done", start_ready, 0);
    exp_p = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("held_product", product, exp_p);
      chk("held_valid", res_valid, 1);
      @(negedge clk);
    end
    chk("product", product, exp_p);
    chk("zero", zero, exp_p == '0);
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    chk("valid_dropped", res_valid, 0);
    chk("start_ready_after", start_ready, 1);
    res_ready = tie_ready;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a_in        = '0;
    b_in        = '0;
    #3;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero", zero, 0);
    chk("rst_product", product, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd13, 8'd11, 0, 1'b0);
    do_op(8'd255, 8'd255, 0, 1'b0);
    do_op(8'd0, 8'd200, 0, 1'b0);
    do_op(8'd255, 8'd0, 0, 1'b0);
    do_op(8'd91, 8'd37, 5, 1'b1);

    // Abort mid-RUN: reset during the fourth RUN cycle.
    start_valid = 1'b1;
    a_in = 8'd200;
    b_in = 8'd77;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_product", product, 0);
    chk("abort_zero", zero, 0);
    chk("abort_start_ready", start_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", res_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    do_op(8'd7, 8'd6, 0, 1'b0);

    do_op(8'd100, 8'd0, 0, 1'b0);
    do_op(8'd100, 8'd3, 0, 1'b0);
    do_op(8'd5, 8'd128, 2, 1'b0);
    do_op(8'd1, 8'd1, 0, 1'b0);

    tie_ready = 1'b1;
    res_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      do_op(A'($urandom), B'($urandom), 0, 1'b0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
